// File: rtl/thor2024_fpu_sequencer_if.sv
// Issue / FPU / writeback signal bundle for the FPU sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface thor2024_fpu_sequencer_if #(
    parameter int TAGW = 6
);
    logic            in_valid;
    logic            in_fpu;
    logic            in_ready;
    logic [7:0]      in_op;
    logic [TAGW-1:0] in_tag;
    logic [63:0]     in_a;
    logic [63:0]     in_b;
    logic [63:0]     in_c;
    logic            flush;
    logic            fpu_start;
    logic [7:0]      fpu_op;
    logic [63:0]     fpu_a;
    logic [63:0]     fpu_b;
    logic [63:0]     fpu_c;
    logic            fpu_done;
    logic [63:0]     fpu_res;
    logic [4:0]      fpu_exc;
    logic            fpu_abort;
    logic            out_valid;
    logic            out_ready;
    logic [TAGW-1:0] out_tag;
    logic [63:0]     out_res;
    logic [5:0]      out_exc;
    logic            busy;

    modport slave (
        input  in_valid, in_fpu, in_op, in_tag, in_a, in_b, in_c, flush,
               fpu_done, fpu_res, fpu_exc, out_ready,
        output in_ready, fpu_start, fpu_op, fpu_a, fpu_b, fpu_c, fpu_abort,
               out_valid, out_tag, out_res, out_exc, busy
    );

    modport master (
        output in_valid, in_fpu, in_op, in_tag, in_a, in_b, in_c, flush,
               fpu_done, fpu_res, fpu_exc, out_ready,
        input  in_ready, fpu_start, fpu_op, fpu_a, fpu_b, fpu_c, fpu_abort,
               out_valid, out_tag, out_res, out_exc, busy
    );
endinterface

// File: rtl/thor2024_fpu_sequencer.sv
// In-order FPU op queue: buffers decoded FPU ops, launches them one at a time
// into the FPU, times out stuck ops and hands tagged results to writeback.
module thor2024_fpu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAGW    = 6,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    thor2024_fpu_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]      op;
        logic [TAGW-1:0] tag;
        logic [63:0]     a;
        logic [63:0]     b;
        logic [63:0]     c;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state, w_state_nxt;
    logic [7:0]      r_timer;
    logic [TAGW-1:0] r_tag;
    logic            r_fpu_start, r_fpu_abort, r_out_valid;
    logic [7:0]      r_fpu_op;
    logic [63:0]     r_fpu_a, r_fpu_b, r_fpu_c, r_out_res;
    logic [TAGW-1:0] r_out_tag;
    logic [5:0]      r_out_exc;

    logic   w_in_ready, w_push, w_pop, w_done, w_tmo, w_release;
    entry_t w_head;

    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = bus.in_valid & bus.in_fpu & w_in_ready & ~bus.flush;
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_release   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = BUSY;
                end
                BUSY: if (bus.fpu_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = HOLD;
                end else if (r_timer == 8'(TIMEOUT)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = HOLD;
                end
                HOLD: if (bus.out_ready) begin
                    w_release = 1'b1;
                    // Chain straight into the next op so throughput is FPU latency + 1.
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{op: bus.in_op, tag: bus.in_tag,
                                         a: bus.in_a, b: bus.in_b, c: bus.in_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_tag       <= '0;
            r_fpu_start <= 1'b0;
            r_fpu_abort <= 1'b0;
            r_fpu_op    <= '0;
            r_fpu_a     <= '0;
            r_fpu_b     <= '0;
            r_fpu_c     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_res   <= '0;
            r_out_exc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fpu_start <= w_pop;
            r_fpu_abort <= w_tmo | (bus.flush & (r_state == BUSY));
            if (bus.flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_done) begin
                    r_out_valid <= 1'b1;
                    r_out_tag   <= r_tag;
                    r_out_res   <= bus.fpu_res;
                    r_out_exc   <= {1'b0, bus.fpu_exc};
                end else if (w_tmo) begin
                    r_out_valid <= 1'b1;
                    r_out_tag   <= r_tag;
                    r_out_res   <= '0;
                    r_out_exc   <= 6'b100000;
                end else if (w_release) begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_pop) begin
                r_fpu_op <= w_head.op;
                r_fpu_a  <= w_head.a;
                r_fpu_b  <= w_head.b;
                r_fpu_c  <= w_head.c;
                r_tag    <= w_head.tag;
                r_timer  <= '0;
            end else if (r_state == BUSY) begin
                r_timer  <= r_timer + 8'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != IDLE) | (r_count != '0);
    assign bus.fpu_start = r_fpu_start;
    assign bus.fpu_abort = r_fpu_abort;
    assign bus.fpu_op    = r_fpu_op;
    assign bus.fpu_a     = r_fpu_a;
    assign bus.fpu_b     = r_fpu_b;
    assign bus.fpu_c     = r_fpu_c;
    assign bus.out_valid = r_out_valid;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_res   = r_out_res;
    assign bus.out_exc   = r_out_exc;
endmodule

// File: tb/tb_thor2024_fpu_sequencer.sv
// Directed bench for the FPU sequencer; a small FPU model answers with a+b.
module tb_thor2024_fpu_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    thor2024_fpu_sequencer_if #(.TAGW(6)) ifc();

    thor2024_fpu_sequencer #(.DEPTH(4), .TAGW(6), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_chk = 0;
    int n_fail = 0;

    // FPU model controls and forced-strobe override
    logic        fpu_en;
    int          fpu_lat;
    logic        m_done, f_done;
    logic [63:0] m_res, f_res;
    assign ifc.fpu_done = m_done | f_done;
    assign ifc.fpu_res  = f_done ? f_res : m_res;
    assign ifc.fpu_exc  = 5'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n = 0;
        while (!ifc.out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.out_valid) chk({tag, " valid_wait"}, 64'(ifc.out_valid), 64'd1);
    endtask

    task automatic push(input logic [7:0] op, input logic [5:0] tag,
                        input logic [63:0] a, input logic [63:0] b);
        ifc.in_valid = 1'b1;
        ifc.in_fpu   = 1'b1;
        ifc.in_op    = op;
        ifc.in_tag   = tag;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_c     = ~a;
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    // FPU model: answers lat cycles after fpu_start, dropped by abort/reset
    initial begin
        bit pend = 0;
        int cnt = 0;
        m_done = 1'b0;
        m_res  = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (rst || ifc.fpu_abort) pend = 0;
            if (ifc.fpu_start) begin
                pend = 1;
                cnt  = fpu_lat;
            end
            if (pend && fpu_en) begin
                if (cnt == 0) begin
                    m_done = 1'b1;
                    m_res  = ifc.fpu_a + ifc.fpu_b;
                    pend   = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ab, k, starts, unstable, bad;
        logic [5:0]  rt;
        logic [63:0] rr;
        rst = 1'b1;
        ifc.in_valid = 0; ifc.in_fpu = 0; ifc.in_op = 0; ifc.in_tag = 0;
        ifc.in_a = 0; ifc.in_b = 0; ifc.in_c = 0; ifc.flush = 0; ifc.out_ready = 0;
        f_done = 0; f_res = 0; fpu_en = 1; fpu_lat = 0;
        repeat (2) @(negedge clk);
        chk("rst in_ready",  64'(ifc.in_ready), 64'd1);
        chk("rst out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst fpu_start", 64'(ifc.fpu_start), 64'd0);
        chk("rst fpu_abort", 64'(ifc.fpu_abort), 64'd0);
        chk("rst busy",      64'(ifc.busy), 64'd0);
        chk("rst out_res",   ifc.out_res, 64'd0);
        chk("rst out_tag",   64'(ifc.out_tag), 64'd0);
        chk("rst out_exc",   64'(ifc.out_exc), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single op, FPU answers in the launch cycle
        ifc.out_ready = 1; fpu_lat = 0;
        push(8'h10, 6'd5, 64'h3FF0000000000000, 64'd0);
        chk("t1 no_early_start", 64'(ifc.fpu_start), 64'd0);
        chk("t1 busy",           64'(ifc.busy), 64'd1);
        @(negedge clk);
        chk("t1 fpu_start", 64'(ifc.fpu_start), 64'd1);
        chk("t1 fpu_op",    64'(ifc.fpu_op), 64'h10);
        @(negedge clk);
        chk("t1 out_valid", 64'(ifc.out_valid), 64'd1);
        chk("t1 out_tag",   64'(ifc.out_tag), 64'd5);
        chk("t1 out_res",   ifc.out_res, 64'h3FF0000000000000);
        chk("t1 out_exc",   64'(ifc.out_exc), 64'd0);
        @(negedge clk);
        chk("t1 valid_drop", 64'(ifc.out_valid), 64'd0);
        chk("t1 idle_busy",  64'(ifc.busy), 64'd0);

        // fill: writeback stalled, op0 parks in HOLD, 4 more fill the FIFO
        ifc.out_ready = 0; fpu_lat = 1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2 ready_%0d", i), 64'(ifc.in_ready), 64'd1);
            push(8'h20 + 8'(i), 6'(i), 64'(i * 100), 64'd1);
        end
        chk("t2 full_ready", 64'(ifc.in_ready), 64'd0);
        ifc.in_valid = 1; ifc.in_fpu = 1; ifc.in_tag = 6'd5;
        ifc.in_a = 64'd500; ifc.in_b = 64'd1; ifc.in_op = 8'h25;
        repeat (3) @(negedge clk);
        chk("t2 still_full", 64'(ifc.in_ready), 64'd0);
        fork
            begin
                k = 0;
                while (!ifc.in_ready && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                chk("t2 slot_free", 64'(ifc.in_ready), 64'd1);
                @(negedge clk);
                ifc.in_valid = 0;
            end
            begin
                ifc.out_ready = 1;
                for (int i = 0; i < 6; i++) begin
                    wait_valid(40, "t2");
                    chk($sformatf("t2 tag_%0d", i), 64'(ifc.out_tag), 64'(i));
                    chk($sformatf("t2 res_%0d", i), ifc.out_res, 64'(i * 100 + 1));
                    @(negedge clk);
                end
            end
        join
        chk("t2 drained", 64'(ifc.busy), 64'd0);

        // timeout with a silent FPU
        fpu_en = 0; ifc.out_ready = 0;
        push(8'h30, 6'd9, 64'd7, 64'd7);
        k = 0;
        while (!ifc.fpu_start && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t3 start_seen", 64'(ifc.fpu_start), 64'd1);
        n = 0; ab = 0;
        while (!ifc.out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (ifc.fpu_abort) ab++;
        end
        chk("t3 latency", 64'(n), 64'd9);
        chk("t3 exc",     64'(ifc.out_exc), 64'h20);
        chk("t3 res",     ifc.out_res, 64'd0);
        chk("t3 tag",     64'(ifc.out_tag), 64'd9);
        @(negedge clk);
        if (ifc.fpu_abort) ab++;
        chk("t3 abort_once", 64'(ab), 64'd1);
        ifc.out_ready = 1;
        @(negedge clk);
        chk("t3 released", 64'(ifc.out_valid), 64'd0);
        fpu_en = 1;

        // backpressure with two ops queued behind the held result
        ifc.out_ready = 0;
        for (int i = 0; i < 3; i++) push(8'h40, 6'(10 + i), 64'(1000 + i), 64'd2);
        wait_valid(20, "t4");
        chk("t4 tag_first", 64'(ifc.out_tag), 64'd10);
        rt = ifc.out_tag; rr = ifc.out_res;
        starts = 0; unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifc.fpu_start) starts++;
            if (!ifc.out_valid || ifc.out_tag != rt || ifc.out_res != rr) unstable++;
        end
        chk("t4 no_start", 64'(starts), 64'd0);
        chk("t4 stable",   64'(unstable), 64'd0);
        chk("t4 res_first", rr, 64'd1002);
        ifc.out_ready = 1;
        @(negedge clk);
        chk("t4 chain_start", 64'(ifc.fpu_start), 64'd1);
        chk("t4 chain_valid", 64'(ifc.out_valid), 64'd0);
        for (int i = 1; i < 3; i++) begin
            wait_valid(20, "t4");
            chk($sformatf("t4 tag_%0d", i), 64'(ifc.out_tag), 64'(10 + i));
            @(negedge clk);
        end
        chk("t4 drained", 64'(ifc.busy), 64'd0);

        // flush in BUSY with 3 queued, same-cycle push and fpu_done
        fpu_en = 0; ifc.out_ready = 1;
        for (int i = 0; i < 4; i++) push(8'h50, 6'(20 + i), 64'(i), 64'd0);
        chk("t5 pre_busy", 64'(ifc.busy), 64'd1);
        ifc.flush = 1; ifc.in_valid = 1; ifc.in_fpu = 1; ifc.in_tag = 6'd24;
        f_done = 1; f_res = 64'd123;
        @(negedge clk);
        ifc.flush = 0; ifc.in_valid = 0; f_done = 0;
        chk("t5 abort",     64'(ifc.fpu_abort), 64'd1);
        chk("t5 out_valid", 64'(ifc.out_valid), 64'd0);
        chk("t5 busy",      64'(ifc.busy), 64'd0);
        chk("t5 in_ready",  64'(ifc.in_ready), 64'd1);
        @(negedge clk);
        chk("t5 abort_once", 64'(ifc.fpu_abort), 64'd0);
        chk("t5 no_start",   64'(ifc.fpu_start), 64'd0);
        chk("t5 still_idle", 64'(ifc.busy), 64'd0);
        chk("t5 no_valid",   64'(ifc.out_valid), 64'd0);

        // non-FPU ops are ignored
        ifc.in_valid = 1; ifc.in_fpu = 0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifc.busy || ifc.fpu_start) bad++;
        end
        ifc.in_valid = 0;
        chk("t6 filter", 64'(bad), 64'd0);

        // async reset in the middle of a launch cycle
        push(8'h60, 6'd30, 64'd1, 64'd1);
        @(negedge clk);
        chk("t6 launched", 64'(ifc.fpu_start), 64'd1);
        #2 rst = 1;
        #1;
        chk("t6 rst_start", 64'(ifc.fpu_start), 64'd0);
        chk("t6 rst_busy",  64'(ifc.busy), 64'd0);
        chk("t6 rst_op",    64'(ifc.fpu_op), 64'd0);
        chk("t6 rst_ready", 64'(ifc.in_ready), 64'd1);
        @(negedge clk);
        chk("t6 rst_noabort", 64'(ifc.fpu_abort), 64'd0);
        rst = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
